bshifter_pipe: RTL

- Parametrised, pipelined barrel shifter. Successor to the team's 8-bit combinational rotate-right shifter.
- Supports four shift modes and any power-of-two data width.
- One register stage per shift bit, so throughput is 1 word/cycle at high clock rates.
- Valid/ready handshake with full back-pressure. Sits between streaming datapath blocks (ALU, packer, CRC feeders).

---
 rtl/bshifter_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bshifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready
// handshake with a combinational ready chain so bubbles are squeezed out.
module bshifter_pipe #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_LSR = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    logic [AW-1:0]    v_q, v_d;
    logic [WIDTH-1:0] d_q    [AW];
    logic [WIDTH-1:0] d_d    [AW];
    logic [AW-1:0]    amt_q  [AW];
    logic [AW-1:0]    amt_d  [AW];
    logic [1:0]       mode_q [AW];
    logic [1:0]       mode_d [AW];

    logic [AW-1:0]    src_v;
    logic [WIDTH-1:0] src_d    [AW];
    logic [AW-1:0]    src_amt  [AW];
    logic [1:0]       src_mode [AW];

    logic [AW-1:0]    adv;
    logic             tail_full;

    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       mode,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        fill = {WIDTH{x[WIDTH-1]}} << (WIDTH - sh);
        case (mode)
            MODE_ROR: return (x >> sh) | (x << (WIDTH - sh));
            MODE_ROL: return (x << sh) | (x >> (WIDTH - sh));
            MODE_LSR: return x >> sh;
            default:  return (x >> sh) | fill;
        endcase
    endfunction

    // A stage may advance unless it and every stage downstream of it is full
    // while the output is stalled.
    always_comb begin
        tail_full = 1'b1;
        adv       = '0;
        for (int k = AW - 1; k >= 0; k--) begin
            tail_full = tail_full & v_q[k];
            adv[k]    = out_ready | ~tail_full;
        end
    end

    always_comb begin
        src_v    = '0;
        src_d    = '{default: '0};
        src_amt  = '{default: '0};
        src_mode = '{default: '0};
        src_v[0]    = in_valid;
        src_d[0]    = in_data;
        src_amt[0]  = in_amt;
        src_mode[0] = in_mode;
        for (int k = 1; k < AW; k++) begin
            src_v[k]    = v_q[k-1];
            src_d[k]    = d_q[k-1];
            src_amt[k]  = amt_q[k-1];
            src_mode[k] = mode_q[k-1];
        end
    end

    // Payload only loads with a valid word, so a bubble leaves the last
    // data in place and never pulls undriven inputs into the pipe.
    always_comb begin
        v_d    = v_q;
        d_d    = d_q;
        amt_d  = amt_q;
        mode_d = mode_q;
        for (int k = 0; k < AW; k++) begin
            if (adv[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    d_d[k]    = src_amt[k][k] ? stage_shift(src_d[k], src_mode[k], 1 << k)
                                              : src_d[k];
                    amt_d[k]  = src_amt[k];
                    mode_d[k] = src_mode[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < AW; k++) begin
                d_q[k]    <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < AW; k++) begin
                d_q[k]    <= d_d[k];
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[AW-1];
    assign out_data  = d_q[AW-1];

endmodule
